// File: rtl/blob_centroid_tracker.sv
// Per-colour blob statistics: live accumulators count pixels continuously while a
// snapshot of the previous frame is reduced to centroids by one shared restoring divider.
module blob_centroid_tracker #(
  parameter int unsigned NUM_COLORS = 4,
  parameter int unsigned COLOR_W    = 2,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 9,
  parameter int unsigned CNT_W      = 19,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [COLOR_W-1:0]       color_i,
  input  logic [XW-1:0]            interesting_x_i,
  input  logic [YW-1:0]            interesting_y_i,
  input  logic                     interesting_flag_i,
  input  logic                     frame_flag_i,
  output logic [NUM_COLORS*XW-1:0] centroid_x_o,
  output logic [NUM_COLORS*YW-1:0] centroid_y_o,
  output logic [NUM_COLORS*XW-1:0] bbox_min_x_o,
  output logic [NUM_COLORS*XW-1:0] bbox_max_x_o,
  output logic [NUM_COLORS*YW-1:0] bbox_min_y_o,
  output logic [NUM_COLORS*YW-1:0] bbox_max_y_o,
  output logic [NUM_COLORS-1:0]    channel_valid_o,
  output logic                     results_valid_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int unsigned SXW = XW + CNT_W;
  localparam int unsigned SYW = YW + CNT_W;
  localparam int unsigned DW  = XW + CNT_W;
  localparam int unsigned KW  = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;
  localparam int unsigned BW  = $clog2(DW + 1);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MinPix  = CNT_W'(MIN_PIXELS);
  localparam logic [KW-1:0]    LastK   = KW'(NUM_COLORS - 1);
  localparam logic [BW-1:0]    LastBit = BW'(DW - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StDivX,
    StDivY,
    StNext,
    StDone
  } state_e;

  state_e state_q;

  // ---------------------------------------------------------------------------
  // Frame boundary detection
  // ---------------------------------------------------------------------------
  logic frame_prev_q;
  logic frame_edge;
  logic snap_load;

  assign frame_edge = frame_flag_i & ~frame_prev_q;
  assign snap_load  = frame_edge & (state_q == StIdle);

  // Previous frame_flag for rising-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_prev_q <= 1'b0;
    end else begin
      frame_prev_q <= frame_flag_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Live accumulators
  // ---------------------------------------------------------------------------
  logic [SXW-1:0]        sum_x_q [NUM_COLORS];
  logic [SXW-1:0]        sum_x_d [NUM_COLORS];
  logic [SYW-1:0]        sum_y_q [NUM_COLORS];
  logic [SYW-1:0]        sum_y_d [NUM_COLORS];
  logic [CNT_W-1:0]      cnt_q   [NUM_COLORS];
  logic [CNT_W-1:0]      cnt_d   [NUM_COLORS];
  logic [XW-1:0]         min_x_q [NUM_COLORS];
  logic [XW-1:0]         min_x_d [NUM_COLORS];
  logic [XW-1:0]         max_x_q [NUM_COLORS];
  logic [XW-1:0]         max_x_d [NUM_COLORS];
  logic [YW-1:0]         min_y_q [NUM_COLORS];
  logic [YW-1:0]         min_y_d [NUM_COLORS];
  logic [YW-1:0]         max_y_q [NUM_COLORS];
  logic [YW-1:0]         max_y_d [NUM_COLORS];
  logic [NUM_COLORS-1:0] hit;

  // Decode which channel the current pixel belongs to; out-of-range colours hit nothing
  always_comb begin
    for (int c = 0; c < NUM_COLORS; c++) begin
      hit[c] = interesting_flag_i && (color_i == COLOR_W'(c));
    end
  end

  // Accumulator next state: a frame edge restarts every channel, seeding it with the
  // pixel sampled in that same cycle; a saturated counter freezes the whole channel
  always_comb begin
    for (int c = 0; c < NUM_COLORS; c++) begin
      sum_x_d[c] = sum_x_q[c];
      sum_y_d[c] = sum_y_q[c];
      cnt_d[c]   = cnt_q[c];
      min_x_d[c] = min_x_q[c];
      max_x_d[c] = max_x_q[c];
      min_y_d[c] = min_y_q[c];
      max_y_d[c] = max_y_q[c];
      if (frame_edge) begin
        if (hit[c]) begin
          sum_x_d[c] = SXW'(interesting_x_i);
          sum_y_d[c] = SYW'(interesting_y_i);
          cnt_d[c]   = CntOne;
          min_x_d[c] = interesting_x_i;
          max_x_d[c] = interesting_x_i;
          min_y_d[c] = interesting_y_i;
          max_y_d[c] = interesting_y_i;
        end else begin
          sum_x_d[c] = '0;
          sum_y_d[c] = '0;
          cnt_d[c]   = '0;
          min_x_d[c] = '0;
          max_x_d[c] = '0;
          min_y_d[c] = '0;
          max_y_d[c] = '0;
        end
      end else if (hit[c] && (cnt_q[c] != CntMax)) begin
        sum_x_d[c] = sum_x_q[c] + SXW'(interesting_x_i);
        sum_y_d[c] = sum_y_q[c] + SYW'(interesting_y_i);
        cnt_d[c]   = cnt_q[c] + CntOne;
        if (cnt_q[c] == '0) begin
          min_x_d[c] = interesting_x_i;
          max_x_d[c] = interesting_x_i;
          min_y_d[c] = interesting_y_i;
          max_y_d[c] = interesting_y_i;
        end else begin
          if (interesting_x_i < min_x_q[c]) min_x_d[c] = interesting_x_i;
          if (interesting_x_i > max_x_q[c]) max_x_d[c] = interesting_x_i;
          if (interesting_y_i < min_y_q[c]) min_y_d[c] = interesting_y_i;
          if (interesting_y_i > max_y_q[c]) max_y_d[c] = interesting_y_i;
        end
      end
    end
  end

  // Live accumulator registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        sum_x_q[c] <= '0;
        sum_y_q[c] <= '0;
        cnt_q[c]   <= '0;
        min_x_q[c] <= '0;
        max_x_q[c] <= '0;
        min_y_q[c] <= '0;
        max_y_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        sum_x_q[c] <= sum_x_d[c];
        sum_y_q[c] <= sum_y_d[c];
        cnt_q[c]   <= cnt_d[c];
        min_x_q[c] <= min_x_d[c];
        max_x_q[c] <= max_x_d[c];
        min_y_q[c] <= min_y_d[c];
        max_y_q[c] <= max_y_d[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot of the completed frame, stable for the whole divider sequence
  // ---------------------------------------------------------------------------
  logic [SXW-1:0]   snap_sum_x_q [NUM_COLORS];
  logic [SYW-1:0]   snap_sum_y_q [NUM_COLORS];
  logic [CNT_W-1:0] snap_cnt_q   [NUM_COLORS];
  logic [XW-1:0]    snap_min_x_q [NUM_COLORS];
  logic [XW-1:0]    snap_max_x_q [NUM_COLORS];
  logic [YW-1:0]    snap_min_y_q [NUM_COLORS];
  logic [YW-1:0]    snap_max_y_q [NUM_COLORS];

  // Capture live values only when the engine is free; an overrun edge leaves these alone
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        snap_sum_x_q[c] <= '0;
        snap_sum_y_q[c] <= '0;
        snap_cnt_q[c]   <= '0;
        snap_min_x_q[c] <= '0;
        snap_max_x_q[c] <= '0;
        snap_min_y_q[c] <= '0;
        snap_max_y_q[c] <= '0;
      end
    end else if (snap_load) begin
      for (int c = 0; c < NUM_COLORS; c++) begin
        snap_sum_x_q[c] <= sum_x_q[c];
        snap_sum_y_q[c] <= sum_y_q[c];
        snap_cnt_q[c]   <= cnt_q[c];
        snap_min_x_q[c] <= min_x_q[c];
        snap_max_x_q[c] <= max_x_q[c];
        snap_min_y_q[c] <= min_y_q[c];
        snap_max_y_q[c] <= max_y_q[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divider step
  // ---------------------------------------------------------------------------
  logic [KW-1:0]    k_q;
  logic [DW-1:0]    dq_q;     // dividend shifting out, quotient shifting in
  logic [CNT_W-1:0] rem_q;
  logic [BW-1:0]    bit_q;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W:0]   trial;
  logic [CNT_W-1:0] diff;
  logic             q_bit;
  logic [CNT_W-1:0] rem_next;
  logic [DW-1:0]    dq_next;

  assign divisor = snap_cnt_q[k_q];

  // One quotient bit per cycle; remainder stays below the divisor so CNT_W bits suffice
  always_comb begin
    trial    = {rem_q, dq_q[DW-1]};
    q_bit    = (trial >= {1'b0, divisor});
    diff     = trial[CNT_W-1:0] - divisor;
    rem_next = q_bit ? diff : trial[CNT_W-1:0];
    dq_next  = {dq_q[DW-2:0], q_bit};
  end

  // ---------------------------------------------------------------------------
  // Sequencer, staging and registered outputs
  // ---------------------------------------------------------------------------
  logic [NUM_COLORS*XW-1:0] stg_cx_q;
  logic [NUM_COLORS*YW-1:0] stg_cy_q;
  logic [NUM_COLORS*XW-1:0] stg_min_x_q;
  logic [NUM_COLORS*XW-1:0] stg_max_x_q;
  logic [NUM_COLORS*YW-1:0] stg_min_y_q;
  logic [NUM_COLORS*YW-1:0] stg_max_y_q;
  logic [NUM_COLORS-1:0]    stg_valid_q;
  logic                     results_valid_q;
  logic                     overrun_q;

  // Walk the channels, dividing qualified ones, then publish everything at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      k_q             <= '0;
      dq_q            <= '0;
      rem_q           <= '0;
      bit_q           <= '0;
      stg_cx_q        <= '0;
      stg_cy_q        <= '0;
      stg_min_x_q     <= '0;
      stg_max_x_q     <= '0;
      stg_min_y_q     <= '0;
      stg_max_y_q     <= '0;
      stg_valid_q     <= '0;
      centroid_x_o    <= '0;
      centroid_y_o    <= '0;
      bbox_min_x_o    <= '0;
      bbox_max_x_o    <= '0;
      bbox_min_y_o    <= '0;
      bbox_max_y_o    <= '0;
      channel_valid_o <= '0;
      results_valid_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      results_valid_q <= 1'b0;
      overrun_q       <= frame_edge && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (frame_edge) begin
            k_q     <= '0;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (divisor < MinPix) begin
            stg_valid_q[k_q]             <= 1'b0;
            stg_cx_q[k_q*XW +: XW]       <= '0;
            stg_cy_q[k_q*YW +: YW]       <= '0;
            stg_min_x_q[k_q*XW +: XW]    <= '0;
            stg_max_x_q[k_q*XW +: XW]    <= '0;
            stg_min_y_q[k_q*YW +: YW]    <= '0;
            stg_max_y_q[k_q*YW +: YW]    <= '0;
            state_q                      <= StNext;
          end else begin
            stg_valid_q[k_q]             <= 1'b1;
            stg_min_x_q[k_q*XW +: XW]    <= snap_min_x_q[k_q];
            stg_max_x_q[k_q*XW +: XW]    <= snap_max_x_q[k_q];
            stg_min_y_q[k_q*YW +: YW]    <= snap_min_y_q[k_q];
            stg_max_y_q[k_q*YW +: YW]    <= snap_max_y_q[k_q];
            dq_q                         <= DW'(snap_sum_x_q[k_q]);
            rem_q                        <= '0;
            bit_q                        <= '0;
            state_q                      <= StDivX;
          end
        end
        StDivX: begin
          dq_q  <= dq_next;
          rem_q <= rem_next;
          bit_q <= bit_q + BW'(1);
          if (bit_q == LastBit) begin
            stg_cx_q[k_q*XW +: XW] <= dq_next[XW-1:0];
            dq_q                   <= DW'(snap_sum_y_q[k_q]);
            rem_q                  <= '0;
            bit_q                  <= '0;
            state_q                <= StDivY;
          end
        end
        StDivY: begin
          dq_q  <= dq_next;
          rem_q <= rem_next;
          bit_q <= bit_q + BW'(1);
          if (bit_q == LastBit) begin
            stg_cy_q[k_q*YW +: YW] <= dq_next[YW-1:0];
            state_q                <= StNext;
          end
        end
        StNext: begin
          if (k_q == LastK) begin
            state_q <= StDone;
          end else begin
            k_q     <= k_q + KW'(1);
            state_q <= StCheck;
          end
        end
        StDone: begin
          centroid_x_o    <= stg_cx_q;
          centroid_y_o    <= stg_cy_q;
          bbox_min_x_o    <= stg_min_x_q;
          bbox_max_x_o    <= stg_max_x_q;
          bbox_min_y_o    <= stg_min_y_q;
          bbox_max_y_o    <= stg_max_y_q;
          channel_valid_o <= stg_valid_q;
          results_valid_q <= 1'b1;
          state_q         <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign results_valid_o = results_valid_q;
  assign overrun_o       = overrun_q;
  assign busy_o          = (state_q != StIdle);

endmodule
